// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port, with credit-based flow control
module fifo_wr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int LOG2DEPTH = 2,
  parameter int BURST     = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic [NREQ-1:0]                               req,
  input  logic [NREQ*WIDTH-1:0]                         din,
  input  logic [NREQ-1:0]                               last,
  output logic [NREQ-1:0]                               gnt,
  output logic [NREQ-1:0]                               ack,
  input  logic                                          fifo_rd,
  output logic                                          fifo_wr_en,
  output logic [WIDTH-1:0]                              fifo_din,
  output logic [($clog2(NREQ) > 1 ? $clog2(NREQ) : 1)-1:0] owner,
  output logic [LOG2DEPTH:0]                            credit
);
  localparam int OW = $clog2(NREQ) > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(BURST + 1);
  localparam logic [LOG2DEPTH:0] FULL = (LOG2DEPTH + 1)'(1 << LOG2DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]    st;
  logic [CW-1:0] cnt;
  logic [OW-1:0] nxt;
  logic          hit;
  logic          acc;
  logic          done;

  assign ack  = gnt & req & {NREQ{credit != '0}};
  assign acc  = |ack;
  assign done = (acc & (last[owner] | (cnt == CW'(BURST - 1)))) | ~req[owner];

  // pick the first requester after the current owner; scanning downward lets the nearest one win
  always_comb begin
    nxt = owner;
    hit = 1'b0;
    for (int i = NREQ; i >= 1; i--)
      if (req[OW'((int'(owner) + i) % NREQ)]) begin
        nxt = OW'((int'(owner) + i) % NREQ);
        hit = 1'b1;
      end
  end

  // grant FSM: IDLE picks a winner, XFER counts beats until last, burst limit or request drop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st    <= IDLE;
      gnt   <= '0;
      owner <= OW'(NREQ - 1);
      cnt   <= '0;
    end else if (st == IDLE) begin
      if (hit) begin
        st    <= XFER;
        gnt   <= NREQ'(1) << nxt;
        owner <= nxt;
        cnt   <= '0;
      end
    end else begin
      if (acc) cnt <= cnt + 1'b1;
      if (done) begin
        st  <= IDLE;
        gnt <= '0;
      end
    end

  // register the accepted beat toward the FIFO; data holds between writes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fifo_wr_en <= 1'b0;
      fifo_din   <= '0;
    end else begin
      fifo_wr_en <= acc;
      if (acc) fifo_din <= din[int'(owner)*WIDTH +: WIDTH];
    end

  // free-entry count: accepts consume, consumer reads return, saturating at full
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) credit <= FULL;
    else if (acc && !fifo_rd) credit <= credit - 1'b1;
    else if (fifo_rd && !acc && credit != FULL) credit <= credit + 1'b1;

  assert property (@(posedge clk) disable iff (!rst_n) !(fifo_rd && credit == FULL));
endmodule
